// File: rtl/memory_unit_pkg.sv
// Shared constants and state/opcode encodings for the memory unit and the CPU side.
package memory_unit_pkg;

    localparam int WORD_SIZE = 16;
    localparam int CNT_BITS  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/memory_unit_if.sv
// Request/response handshake between a CPU and the memory unit; the data bus is a separate inout.
interface memory_unit_if #(
    parameter int WORD_SIZE = memory_unit_pkg::WORD_SIZE
) ();

    logic                 read_m;
    logic                 write_m;
    logic [WORD_SIZE-1:0] address;
    logic                 mem_ready;
    logic                 busy;
    logic                 err;
    logic [WORD_SIZE-1:0] num_access;

    modport master (
        output read_m, write_m, address,
        input  mem_ready, busy, err, num_access
    );

    modport slave (
        input  read_m, write_m, address,
        output mem_ready, busy, err, num_access
    );

endinterface

// File: rtl/memory_unit_mem_array.sv
// Word storage: synchronous write, asynchronous read, contents survive reset.
module mem_array #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem [1 << ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_unit.sv
// Fixed-latency memory unit: accepts one read or write from IDLE, completes LATENCY cycles later.
module memory_unit
    import memory_unit_pkg::*;
#(
    parameter int WORD_SIZE = memory_unit_pkg::WORD_SIZE,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                clk,
    input  logic                reset,
    memory_unit_if.slave        bus,
    inout  wire [WORD_SIZE-1:0] data
);

    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

    state_t               state, next_state;
    op_t                  op_q, next_op;
    logic                 accept, illegal, finish;
    logic [CNT_BITS-1:0]  cnt_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rdata;
    logic                 mem_ready_q, busy_q, err_q, drive_q;
    logic [WORD_SIZE-1:0] num_access_q;
    logic                 unused_addr_hi;

    // Upper address bits alias onto the low ADDR_BITS.
    assign unused_addr_hi = ^bus.address[WORD_SIZE-1:ADDR_BITS];

    always_comb begin
        next_state = state;
        next_op    = op_q;
        accept     = 1'b0;
        illegal    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.read_m && bus.write_m) begin
                    illegal = 1'b1;
                end else if (bus.read_m || bus.write_m) begin
                    accept     = 1'b1;
                    next_op    = bus.write_m ? OP_WRITE : OP_READ;
                    next_state = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_BITS'(1)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The edge that ends DONE commits writes and counts the access, unless reset aborts it.
    assign finish = (state == DONE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt_q        <= '0;
            mem_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            drive_q      <= 1'b0;
            num_access_q <= '0;
        end else begin
            state       <= next_state;
            mem_ready_q <= (next_state == DONE);
            busy_q      <= (next_state != IDLE);
            err_q       <= illegal;
            drive_q     <= (next_state == DONE) && (next_op == OP_READ);
            if (accept) begin
                cnt_q <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt_q <= cnt_q - CNT_BITS'(1);
            end
            if (finish) begin
                num_access_q <= num_access_q + WORD_SIZE'(1);
            end
        end
    end

    // Request capture: frozen after acceptance so later bus activity cannot disturb it.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= next_op;
            addr_q  <= bus.address[ADDR_BITS-1:0];
            wdata_q <= data;
        end
    end

    mem_array #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (finish && (op_q == OP_WRITE)),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (addr_q),
        .rdata (rdata)
    );

    assign bus.mem_ready  = mem_ready_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
    assign bus.num_access = num_access_q;
    assign data           = drive_q ? rdata : 'z;

endmodule

// File: tb/tb_memory_unit.sv
// Randomized bench for memory_unit: a 16-bit LATENCY=2 unit and an 8-bit LATENCY=1 unit against an array model.
module tb_memory_unit;

    localparam int W0 = 16, A0 = 8, L0 = 2;
    localparam int W1 = 8,  A1 = 4, L1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst  [2];
    logic        rd   [2];
    logic        wr   [2];
    logic        oe   [2];
    logic [15:0] addr [2];
    logic [15:0] wdat [2];

    memory_unit_if #(.WORD_SIZE(W0)) bus0 ();
    memory_unit_if #(.WORD_SIZE(W1)) bus1 ();

    // Released bus reads back as zero.
    tri0 [W0-1:0] data0;
    tri0 [W1-1:0] data1;

    assign bus0.read_m  = rd[0];
    assign bus0.write_m = wr[0];
    assign bus0.address = addr[0];
    assign bus1.read_m  = rd[1];
    assign bus1.write_m = wr[1];
    assign bus1.address = addr[1][W1-1:0];
    assign data0 = oe[0] ? wdat[0] : 'z;
    assign data1 = oe[1] ? wdat[1][W1-1:0] : 'z;

    memory_unit #(.WORD_SIZE(W0), .ADDR_BITS(A0), .LATENCY(L0)) dut0 (
        .clk   (clk),
        .reset (rst[0]),
        .bus   (bus0),
        .data  (data0)
    );

    memory_unit #(.WORD_SIZE(W1), .ADDR_BITS(A1), .LATENCY(L1)) dut1 (
        .clk   (clk),
        .reset (rst[1]),
        .bus   (bus1),
        .data  (data1)
    );

    // Reference model: plain word arrays indexed modulo their size, plus an access counter.
    logic [15:0] mdl0 [1 << A0];
    logic [15:0] mdl1 [1 << A1];
    logic [15:0] mcnt [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] wmask(input int w);
        return (w == 0) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic int lat(input int w);
        return (w == 0) ? L0 : L1;
    endfunction

    function automatic logic [15:0] mdl_get(input int w, input logic [15:0] a);
        return (w == 0) ? mdl0[a[A0-1:0]] : mdl1[a[A1-1:0]];
    endfunction

    task automatic mdl_put(input int w, input logic [15:0] a, input logic [15:0] d);
        if (w == 0) mdl0[a[A0-1:0]] = d;
        else        mdl1[a[A1-1:0]] = d & 16'h00FF;
    endtask

    function automatic logic obs_ready(input int w);
        return (w == 0) ? bus0.mem_ready : bus1.mem_ready;
    endfunction

    function automatic logic obs_busy(input int w);
        return (w == 0) ? bus0.busy : bus1.busy;
    endfunction

    function automatic logic obs_err(input int w);
        return (w == 0) ? bus0.err : bus1.err;
    endfunction

    function automatic logic [15:0] obs_cnt(input int w);
        return (w == 0) ? bus0.num_access : {8'h00, bus1.num_access};
    endfunction

    function automatic logic [15:0] obs_data(input int w);
        return (w == 0) ? data0 : {8'h00, data1};
    endfunction

    task automatic check_idle(input int w, input string tag);
        check_eq({tag, "_ready"}, obs_ready(w), 1'b0);
        check_eq({tag, "_busy"},  obs_busy(w),  1'b0);
        check_eq({tag, "_err"},   obs_err(w),   1'b0);
        check_eq({tag, "_cnt"},   obs_cnt(w),   mcnt[w]);
        check_eq({tag, "_bus"},   obs_data(w),  16'h0000);
    endtask

    // Starts and ends at a falling edge with the unit idle.
    task automatic do_op(input int w, input bit is_wr, input logic [15:0] a, input logic [15:0] d,
                         input bit scramble, output logic [15:0] got, output int ready_at);
        int          waited;
        logic [15:0] exp_rd;
        exp_rd  = mdl_get(w, a);
        addr[w] = a;
        wdat[w] = d & wmask(w);
        oe[w]   = is_wr;
        rd[w]   = !is_wr;
        wr[w]   = is_wr;
        @(negedge clk);
        waited = 1;
        if (scramble) begin
            addr[w] = 16'($urandom);
            wdat[w] = 16'($urandom) & wmask(w);
            rd[w]   = 1'b1;
            wr[w]   = 1'b1;
        end
        while (!obs_ready(w) && waited < 20) begin
            check_eq("wait_busy", obs_busy(w), 1'b1);
            check_eq("wait_err", obs_err(w), 1'b0);
            if (!is_wr) check_eq("wait_bus", obs_data(w), 16'h0000);
            @(negedge clk);
            waited++;
        end
        check_eq("latency", waited, lat(w));
        got      = obs_data(w);
        ready_at = cyc;
        if (obs_ready(w)) begin
            check_eq("done_busy", obs_busy(w), 1'b1);
            if (!is_wr) check_eq("rd_data", got, exp_rd);
        end
        rd[w] = 1'b0;
        wr[w] = 1'b0;
        oe[w] = 1'b0;
        @(negedge clk);
        if (is_wr) mdl_put(w, a, d);
        mcnt[w] = (mcnt[w] + 16'd1) & wmask(w);
        check_idle(w, "post");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] got, a, d;
        int          t0, t1;
        bit          is_wr, scr;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; oe[i] = 1'b0;
            addr[i] = '0; wdat[i] = '0; mcnt[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_idle(0, "rst0");
        check_idle(1, "rst1");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        // Fill every word through the bus, with random aliasing upper address bits.
        for (int i = 0; i < (1 << A0); i++) begin
            a = 16'($urandom);
            a[A0-1:0] = A0'(i);
            do_op(0, 1'b1, a, 16'($urandom), 1'b0, got, t0);
        end
        do_op(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, got, t0);
        do_op(0, 1'b1, 16'h0030, 16'h0000, 1'b0, got, t0);

        // Reset clears the counter but keeps the array.
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        mcnt[0] = '0;
        @(negedge clk);
        check_idle(0, "rst_keep");

        do_op(0, 1'b0, 16'h0010, 16'h0000, 1'b0, got, t0);
        check_eq("beef_data", got, 16'hBEEF);
        check_eq("beef_cnt", obs_cnt(0), 16'd1);

        do_op(0, 1'b1, 16'h0020, 16'h1234, 1'b0, got, t0);
        do_op(0, 1'b0, 16'h0020, 16'h0000, 1'b0, got, t0);
        check_eq("rd_0020", got, 16'h1234);
        do_op(0, 1'b0, 16'h0120, 16'h0000, 1'b0, got, t0);
        check_eq("rd_0120_alias", got, 16'h1234);

        // Illegal request: both strobes high in IDLE.
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0040;
        @(negedge clk);
        check_eq("illegal_err", obs_err(0), 1'b1);
        check_eq("illegal_busy", obs_busy(0), 1'b0);
        check_eq("illegal_ready", obs_ready(0), 1'b0);
        rd[0] = 1'b0; wr[0] = 1'b0;
        @(negedge clk);
        check_idle(0, "illegal_after");

        // Reset during WAIT aborts a write.
        addr[0] = 16'h0030; wdat[0] = 16'h5555; oe[0] = 1'b1; wr[0] = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", obs_busy(0), 1'b1);
        rst[0] = 1'b1; wr[0] = 1'b0; oe[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0;
        mcnt[0] = '0;
        check_idle(0, "abort");
        @(negedge clk);
        check_idle(0, "abort_late");
        do_op(0, 1'b0, 16'h0030, 16'h0000, 1'b0, got, t0);
        check_eq("abort_mem", got, 16'h0000);

        // Reset wins over a simultaneous request.
        rst[0] = 1'b1; rd[0] = 1'b1; addr[0] = 16'h0010;
        @(negedge clk);
        rst[0] = 1'b0; rd[0] = 1'b0;
        mcnt[0] = '0;
        check_idle(0, "rst_prio");
        @(negedge clk);
        check_idle(0, "rst_prio2");

        for (int i = 0; i < 300; i++) begin
            is_wr = 1'($urandom_range(0, 1));
            scr   = 1'($urandom_range(0, 1));
            do_op(0, is_wr, 16'($urandom), 16'($urandom), scr, got, t0);
        end

        // LATENCY=1 unit.
        for (int i = 0; i < (1 << A1); i++) begin
            a = 16'($urandom);
            a[A1-1:0] = A1'(i);
            do_op(1, 1'b1, a, 16'($urandom), 1'b0, got, t0);
        end
        do_op(1, 1'b1, 16'h0001, 16'h00A1, 1'b0, got, t0);
        do_op(1, 1'b1, 16'h0002, 16'h00B2, 1'b0, got, t0);
        do_op(1, 1'b0, 16'h0001, 16'h0000, 1'b0, got, t0);
        check_eq("b2b_first", got, 16'h00A1);
        do_op(1, 1'b0, 16'h0002, 16'h0000, 1'b0, got, t1);
        check_eq("b2b_second", got, 16'h00B2);
        check_eq("b2b_gap", t1 - t0, 2);

        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        mcnt[1] = '0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            is_wr = 1'($urandom_range(0, 1));
            d     = 16'($urandom);
            do_op(1, is_wr, 16'($urandom), d, 1'b0, got, t0);
            if (i == 254) check_eq("cnt_top", obs_cnt(1), 16'h00FF);
        end
        check_eq("cnt_wrap", obs_cnt(1), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data and address word width.
REQ-002 SHALL have parameter ADDR_BITS, default 8, giving 2^ADDR_BITS words of storage.
REQ-003 SHALL have parameter LATENCY, default 2, legal 1..7, cycles from request sample to completion.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port read_m  input  1  CPU read request, level, held until mem_ready.
REQ-007 SHALL have port write_m  input  1  CPU write request, level, held until mem_ready.
REQ-008 SHALL have port address  input  WORD_SIZE  CPU word address.
REQ-009 SHALL have port data  inout  WORD_SIZE  shared bus; CPU drives on write, unit drives on read completion.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  high while a request is in flight (WAIT or DONE).
REQ-012 SHALL have port err  output  1  one-cycle pulse on illegal request (read_m and write_m both high).
REQ-013 SHALL have port num_access  output  WORD_SIZE  count of completed accesses.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-015 In IDLE with exactly one of read_m/write_m high, SHALL latch op, address[ADDR_BITS-1:0], and (write) data bus value on that edge.
REQ-016 After that edge, SHALL enter DONE if LATENCY=1, else WAIT with countdown of LATENCY-1.
REQ-017 In WAIT, SHALL decrement per cycle and enter DONE such that mem_ready is high exactly LATENCY cycles after the accepting cycle.
REQ-018 In DONE, SHALL assert mem_ready for exactly one cycle, then return to IDLE.
REQ-019 For a read in DONE, SHALL drive data with mem[latched address]; the bus is high-Z at all other times.
REQ-020 For a write, SHALL commit the latched data to the array on the edge ending DONE; no earlier.
REQ-021 Address bits above ADDR_BITS SHALL be ignored (wrap-around; 0x0105 aliases 0x0005 at ADDR_BITS=8).
REQ-022 read_m and write_m both high in IDLE: no request accepted, state stays IDLE, err pulses next cycle.
REQ-023 Request signals in WAIT/DONE SHALL be ignored; the earliest new acceptance is the cycle after DONE.
REQ-024 num_access SHALL increment on each edge ending DONE, wrapping 0xFFFF to 0x0000.
REQ-025 Latched address/data SHALL be insensitive to input changes after acceptance.

Reset
REQ-026 reset high at a rising edge SHALL force IDLE, mem_ready=0, busy=0, err=0, num_access=0, data high-Z.
REQ-027 reset mid-operation (WAIT or DONE) SHALL abort the request with no array write and no mem_ready pulse.
REQ-028 Array contents SHALL NOT be cleared by reset; they are preloaded by the bench.
REQ-029 reset SHALL take priority over any simultaneous request.

Structure
REQ-030 WORD_SIZE and FSM state encodings SHALL live in the shared opcode/constants header used by the CPU.
REQ-031 The storage array SHALL be the single sub-module mem_array (sync write, async read, no reset).
REQ-032 Top-level output logic SHALL be registered except the data tristate driver.

Verification
REQ-033 Preload mem[0x10]=0xBEEF, LATENCY=2, read 0x0010 -> mem_ready high 2 cycles after accept, data=0xBEEF that cycle, num_access=1.
REQ-034 Write 0x1234 to 0x0020 then read 0x0020 -> read returns 0x1234; address 0x0120 also returns 0x1234.
REQ-035 read_m=write_m=1 in IDLE -> err one-cycle pulse, busy stays 0, no mem_ready, num_access unchanged.
REQ-036 Write 0x5555 to 0x0030 (old 0x0000), reset asserted in WAIT -> IDLE, no mem_ready, mem[0x30] still 0x0000.
REQ-037 LATENCY=1, back-to-back reads 0x01, 0x02 held until mem_ready -> ready every other cycle, data bus high-Z between.
REQ-038 Preload num_access path with 65536 completions -> num_access wraps to 0x0000.
